// File: rtl/ex_flag_stack_if.sv
// Pipeline-control / flag bus between the Execute stage and ex_flag_stack.
// The master drives compare/push/pop/branch controls; the slave returns flags, taken and stack status.
interface ex_flag_stack_if #(
    parameter int unsigned FLAG_W = 2,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic              cmp;
    logic [FLAG_W-1:0] alu_flags;
    logic              push;
    logic              pop;
    logic              br_valid;
    logic [2:0]        cond;
    logic              err_clr;
    logic [FLAG_W-1:0] flags_out;
    logic              taken;
    logic [DW-1:0]     depth;
    logic              full;
    logic              empty;
    logic              err;

    modport master (
        output cmp, alu_flags, push, pop, br_valid, cond, err_clr,
        input  flags_out, taken, depth, full, empty, err
    );

    modport slave (
        input  cmp, alu_flags, push, pop, br_valid, cond, err_clr,
        output flags_out, taken, depth, full, empty, err
    );
endinterface

// File: rtl/ex_flag_stack.sv
// Execute-stage condition flags with a DEPTH-deep save LIFO and a registered branch resolver.
// Optional macro FLAG_BYPASS_EN: same-cycle compare flags feed branch evaluation.
module ex_flag_stack #(
    parameter int unsigned FLAG_W = 2,
    parameter int unsigned DEPTH  = 4
) (
    input logic          clk,
    input logic          rst,
    ex_flag_stack_if.slave bus
);
    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAG_W-1:0] r_cur;
    logic [FLAG_W-1:0] r_stack [DEPTH];
    logic [DW-1:0]     r_sp;
    logic              r_taken;
    logic              r_err;

    logic              w_empty;
    logic              w_full;
    logic [AW-1:0]     w_top_idx;
    logic [FLAG_W-1:0] w_top;
    logic [FLAG_W-1:0] w_cur_nxt;
    logic [DW-1:0]     w_sp_nxt;
    logic              w_wr_en;
    logic [AW-1:0]     w_wr_idx;
    logic              w_err_set;
    logic              w_z;
    logic              w_n;
    logic              w_cond_hit;

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == DW'(DEPTH));
    assign w_top_idx = AW'(r_sp - 1'b1);
    assign w_top     = r_stack[w_top_idx];

    // Stack/flag next-state: first matching rule of pop/push priority.
    always_comb begin
        w_cur_nxt = bus.cmp ? bus.alu_flags : r_cur;
        w_sp_nxt  = r_sp;
        w_wr_en   = 1'b0;
        w_wr_idx  = AW'(r_sp);
        w_err_set = 1'b0;
        if (bus.pop && bus.push) begin
            if (!w_empty) begin
                w_cur_nxt = w_top;
                w_wr_en   = 1'b1;
                w_wr_idx  = w_top_idx;
            end else begin
                w_wr_en   = 1'b1;
                w_sp_nxt  = r_sp + 1'b1;
                w_err_set = 1'b1;
            end
        end else if (bus.pop) begin
            if (!w_empty) begin
                w_cur_nxt = w_top;
                w_sp_nxt  = r_sp - 1'b1;
            end else begin
                w_err_set = 1'b1;
            end
        end else if (bus.push) begin
            if (!w_full) begin
                w_wr_en  = 1'b1;
                w_sp_nxt = r_sp + 1'b1;
            end else begin
                w_err_set = 1'b1;
            end
        end
    end

    // Flags seen by the branch resolver; only Z and N matter.
    always_comb begin
        w_z = r_cur[0];
        w_n = r_cur[1];
`ifdef FLAG_BYPASS_EN
        if (bus.cmp && !bus.pop) begin
            w_z = bus.alu_flags[0];
            w_n = bus.alu_flags[1];
        end
`endif
        case (bus.cond)
            3'b000:  w_cond_hit = 1'b0;
            3'b001:  w_cond_hit = 1'b1;
            3'b010:  w_cond_hit = w_z;
            3'b011:  w_cond_hit = !w_z;
            3'b100:  w_cond_hit = w_n;
            3'b101:  w_cond_hit = !w_n;
            3'b110:  w_cond_hit = w_z | w_n;
            default: w_cond_hit = !w_z & !w_n;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur   <= '0;
            r_sp    <= '0;
            r_taken <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_cur   <= w_cur_nxt;
            r_sp    <= w_sp_nxt;
            r_taken <= bus.br_valid & w_cond_hit;
            r_err   <= w_err_set | (r_err & !bus.err_clr);
            if (w_wr_en) begin
                r_stack[w_wr_idx] <= r_cur;
            end
        end
    end

    assign bus.flags_out = r_cur;
    assign bus.taken     = r_taken;
    assign bus.depth     = r_sp;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_ex_flag_stack.sv
// Randomised and directed bench for ex_flag_stack against a queue-based reference model.
module tb_ex_flag_stack;
    localparam int unsigned FW = 2;
    localparam int unsigned DP = 4;
    localparam int unsigned DW = $clog2(DP + 1);

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ex_flag_stack_if #(.FLAG_W(FW), .DEPTH(DP)) bus ();

    ex_flag_stack #(.FLAG_W(FW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [FW-1:0] m_q [$];
    logic [FW-1:0] m_cur;
    logic          m_err;
    logic          m_taken;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic branch_ok(input logic [2:0] cd, input logic [FW-1:0] f);
        bit z = f[0];
        bit n = f[1];
        if (cd == 3'd0) return 1'b0;
        if (cd == 3'd1) return 1'b1;
        if (cd == 3'd2) return z;
        if (cd == 3'd3) return !z;
        if (cd == 3'd4) return n;
        if (cd == 3'd5) return !n;
        if (cd == 3'd6) return z || n;
        return !z && !n;
    endfunction

    task automatic model(input logic c, input logic [FW-1:0] a, input logic pu, input logic po,
                         input logic bv, input logic [2:0] cd, input logic ec, input logic r);
        logic [FW-1:0] bf;
        logic [FW-1:0] tmp;
        logic          e;
        if (r) begin
            m_q.delete();
            m_cur = '0;
            m_err = 1'b0;
            m_taken = 1'b0;
            return;
        end
        bf = m_cur;
`ifdef FLAG_BYPASS_EN
        if (c && !po) bf = a;
`endif
        m_taken = bv ? branch_ok(cd, bf) : 1'b0;
        e = 1'b0;
        if (po && pu) begin
            if (m_q.size() > 0) begin
                tmp = m_q[$];
                m_q[$] = m_cur;
                m_cur = tmp;
            end else begin
                m_q.push_back(m_cur);
                if (c) m_cur = a;
                e = 1'b1;
            end
        end else if (po) begin
            if (m_q.size() > 0) m_cur = m_q.pop_back();
            else begin
                e = 1'b1;
                if (c) m_cur = a;
            end
        end else begin
            if (pu) begin
                if (m_q.size() < DP) m_q.push_back(m_cur);
                else e = 1'b1;
            end
            if (c) m_cur = a;
        end
        m_err = e | (m_err & !ec);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".flags"}, 32'(bus.flags_out), 32'(m_cur));
        check({tag, ".taken"}, 32'(bus.taken), 32'(m_taken));
        check({tag, ".depth"}, 32'(bus.depth), 32'(m_q.size()));
        check({tag, ".full"},  32'(bus.full),  32'(m_q.size() == DP));
        check({tag, ".empty"}, 32'(bus.empty), 32'(m_q.size() == 0));
        check({tag, ".err"},   32'(bus.err),   32'(m_err));
    endtask

    // One clock: drive at negedge, model after the edge, compare at next negedge.
    task automatic step(input string tag, input logic c, input logic [FW-1:0] a, input logic pu,
                        input logic po, input logic bv, input logic [2:0] cd, input logic ec,
                        input logic r);
        rst = r;
        bus.cmp = c;
        bus.alu_flags = a;
        bus.push = pu;
        bus.pop = po;
        bus.br_valid = bv;
        bus.cond = cd;
        bus.err_clr = ec;
        @(posedge clk);
        model(c, a, pu, po, bv, cd, ec, r);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_tk;
        logic       exp_bp;
        clk = 1'b0;
        n_tests = 0;
        n_fail = 0;
        m_cur = '0;
        m_err = 1'b0;
        m_taken = 1'b0;
        @(negedge clk);

        // Reset then always-branch
        step("rst0", 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        step("rst1", 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        check("rst.empty_const", 32'(bus.empty), 32'd1);
        step("br_always", 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        check("rst.taken_const", 32'(bus.taken), 32'd1);
        idle("taken_drop");
        check("taken_one_cycle", 32'(bus.taken), 32'd0);

        // Nesting
        step("n_cmp01", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step("n_push1", 1'b0, '0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step("n_cmp10", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step("n_push2", 1'b0, '0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("nest.depth_const", 32'(bus.depth), 32'd2);
        step("n_cmp11", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step("n_pop1", 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        check("nest.pop1_const", 32'(bus.flags_out), 32'd2);
        step("n_pop2", 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        check("nest.pop2_const", 32'(bus.flags_out), 32'd1);

        // Overflow then LIFO drain
        for (int i = 0; i < 5; i++)
            step("ovf_push", 1'b1, FW'(i + 1), 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("ovf.err_const", 32'(bus.err), 32'd1);
        check("ovf.depth_const", 32'(bus.depth), 32'(DP));
        for (int i = 0; i < 4; i++)
            step("ovf_pop", 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        // Underflow, clear, exchange
        step("udf_pop", 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        step("err_clr", 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        check("clr.err_const", 32'(bus.err), 32'd0);
        step("x_cmp01", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step("x_push", 1'b0, '0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step("x_cmp10", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step("x_xchg", 1'b0, '0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        check("xchg.cur_const", 32'(bus.flags_out), 32'd1);
        step("x_pop", 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        check("xchg.top_const", 32'(bus.flags_out), 32'd2);

        // Branch walk with Z=1, N=0
        exp_tk = 8'b0110_0110;
        step("b_set", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step("b_walk", 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'(i), 1'b0, 1'b0);
            check("b_walk_const", 32'(bus.taken), 32'(exp_tk[i]));
        end

        // Same-cycle compare and branch
`ifdef FLAG_BYPASS_EN
        exp_bp = 1'b1;
`else
        exp_bp = 1'b0;
`endif
        step("bp_clr", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step("bp_br", 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        check("bypass_const", 32'(bus.taken), 32'(exp_bp));

        // Random traffic, including occasional mid-sequence resets
        for (int i = 0; i < 600; i++) begin
            step("rnd",
                 1'($urandom_range(0, 1)), FW'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 3'($urandom),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 79) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
